lifo_ctl: RTL and testbench

- Command sequencer in front of one lifo8x8 stack instance.
- Accepts stack-machine ops (PUSH/POP/DUP/DROP/SWAP/OVER/CLEAR) over a valid/ready port and drives the LIFO push/pop/data strobes, expanding SWAP into a 3-cycle strobe sequence.
- Tracks stack depth so that underflow and overflow are rejected instead of silently losing s7 or reading stale data.

---
 rtl/lifo_ctl_if.sv | 29 ++
 rtl/lifo_ctl.sv | 104 ++++++++++
 tb/tb_lifo_ctl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lifo_ctl_if.sv
// lifo_ctl_if: command port and LIFO strobe/data bus for lifo_ctl
// Command side carries valid/ready/op/data and returns done/err/result/depth/empty/full.
// LIFO side carries data/push/pop to the stack and its top two entries s0/s1 back.
// The master modport belongs to the requester and LIFO owner; the slave modport belongs to the controller.
interface lifo_ctl_if #(parameter int WIDTH = 8) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    logic [3:0]       depth;
    logic             empty;
    logic             full;
    logic [WIDTH-1:0] lifo_data;
    logic             lifo_push;
    logic             lifo_pop;
    logic [WIDTH-1:0] lifo_s0;
    logic [WIDTH-1:0] lifo_s1;
    modport master (
        output cmd_valid, cmd_op, cmd_data, lifo_s0, lifo_s1,
        input  cmd_ready, done, err, result, depth, empty, full, lifo_data, lifo_push, lifo_pop
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, lifo_s0, lifo_s1,
        output cmd_ready, done, err, result, depth, empty, full, lifo_data, lifo_push, lifo_pop
    );
endinterface

// File: rtl/lifo_ctl.sv
// lifo_ctl: stack-machine command sequencer in front of a lifo8x8 stack
// Ports: clk (rising edge), rst_n (asynchronous, active-low), bus (lifo_ctl_if.slave).
// Accepts PUSH/POP/DUP/DROP/SWAP/OVER/CLEAR/NOP and tracks depth so that
// underflow and overflow are rejected rather than corrupting the stack.
module lifo_ctl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    lifo_ctl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EXEC, SW_POP, SW_REP, SW_PUSH} state_t;
    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3;
    localparam logic [2:0] DROP = 3'd4, SWAP = 3'd5, OVER = 3'd6, CLEAR = 3'd7;
    localparam logic [3:0] CAP = 4'(DEPTH);
    state_t           state;
    logic [WIDTH-1:0] a, b;
    logic             legal;
    logic [2:0]       op;
    logic [3:0]       d;
    assign op = bus.cmd_op;
    assign d = bus.depth;
    assign bus.cmd_ready = (state == IDLE);
    assign bus.empty = (bus.depth == 4'd0);
    assign bus.full = (bus.depth == CAP);
    always_comb begin
        legal = (op == PUSH)               ? (d < CAP) :
                (op == POP || op == DROP)  ? (d != 4'd0) :
                (op == DUP)                ? (d != 4'd0 && d < CAP) :
                (op == SWAP)               ? (d >= 4'd2) :
                (op == OVER)               ? (d >= 4'd2 && d < CAP) : 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.depth     <= '0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.result    <= '0;
            bus.lifo_push <= 1'b0;
            bus.lifo_pop  <= 1'b0;
            bus.lifo_data <= '0;
            a             <= '0;
            b             <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    // operands are captured at accept so later strobes cannot disturb them
                    a <= bus.lifo_s0;
                    b <= bus.lifo_s1;
                    if (!legal) begin
                        bus.done <= 1'b1;
                        bus.err  <= 1'b1;
                    end else if (op == NOP || op == CLEAR) begin
                        bus.done <= 1'b1;
                        if (op == CLEAR) begin
                            bus.depth  <= '0;
                            bus.result <= '0;
                        end
                    end else if (op == SWAP) begin
                        state        <= SW_POP;
                        bus.lifo_pop <= 1'b1;
                    end else begin
                        state         <= EXEC;
                        bus.lifo_push <= (op == PUSH || op == DUP || op == OVER);
                        bus.lifo_pop  <= (op == POP || op == DROP);
                        bus.lifo_data <= (op == PUSH) ? bus.cmd_data :
                                         (op == DUP)  ? bus.lifo_s0 :
                                         (op == OVER) ? bus.lifo_s1 : bus.lifo_data;
                    end
                end
                EXEC: begin
                    state         <= IDLE;
                    bus.lifo_push <= 1'b0;
                    bus.lifo_pop  <= 1'b0;
                    bus.done      <= 1'b1;
                    bus.depth     <= bus.lifo_push ? bus.depth + 4'd1 : bus.depth - 4'd1;
                    bus.result    <= bus.lifo_push ? bus.lifo_data : a;
                end
                SW_POP: begin
                    // push+pop together replaces the top: b is overwritten by a
                    state         <= SW_REP;
                    bus.lifo_push <= 1'b1;
                    bus.lifo_data <= a;
                end
                SW_REP: begin
                    state         <= SW_PUSH;
                    bus.lifo_pop  <= 1'b0;
                    bus.lifo_data <= b;
                end
                SW_PUSH: begin
                    state         <= IDLE;
                    bus.lifo_push <= 1'b0;
                    bus.done      <= 1'b1;
                    bus.result    <= b;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lifo_ctl.sv
// tb_lifo_ctl: directed scoreboard bench for lifo_ctl with a behavioural lifo8x8
module tb_lifo_ctl;
    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3;
    localparam logic [2:0] DROP = 3'd4, SWAP = 3'd5, OVER = 3'd6, CLEAR = 3'd7;
    typedef struct {
        logic       err;
        logic [7:0] res;
        logic [3:0] dep;
        int         nstb;
        int         lat;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lm [8];
    logic [9:0] slog [$];
    logic [7:0] sm [$];
    exp_t       q [$];
    logic [7:0] last_res = 8'h00;
    int         base = 0;
    int         npass = 0;
    int         ntot = 0;
    always #5 clk = ~clk;
    lifo_ctl_if #(.WIDTH(8)) bus ();
    lifo_ctl #(.WIDTH(8), .DEPTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    assign bus.lifo_s0 = lm[0];
    assign bus.lifo_s1 = lm[1];
    // behavioural lifo8x8: push shifts down (s7 lost), pop shifts up, both replaces top
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) lm[i] <= 8'h00;
        end else if (bus.lifo_push && bus.lifo_pop) begin
            lm[0] <= bus.lifo_data;
        end else if (bus.lifo_push) begin
            for (int i = 7; i > 0; i--) lm[i] <= lm[i-1];
            lm[0] <= bus.lifo_data;
        end else if (bus.lifo_pop) begin
            for (int i = 0; i < 7; i++) lm[i] <= lm[i+1];
            lm[7] <= 8'h00;
        end
    end
    always @(posedge clk) if (bus.lifo_push || bus.lifo_pop)
        slog.push_back({bus.lifo_push, bus.lifo_pop, bus.lifo_data});
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask
    task automatic cmd(input logic [2:0] op, input logic [7:0] dv);
        exp_t e;
        logic ok;
        logic [7:0] t;
        int n;
        int sz;
        sz = sm.size();
        ok = (op == PUSH) ? sz < 8 :
             (op == POP || op == DROP) ? sz >= 1 :
             (op == DUP) ? (sz >= 1 && sz < 8) :
             (op == SWAP) ? sz >= 2 :
             (op == OVER) ? (sz >= 2 && sz < 8) : 1'b1;
        e.err = !ok;
        e.res = last_res;
        e.nstb = 0;
        e.lat = 1;
        if (ok) begin
            case (op)
                PUSH: begin sm.push_front(dv); e.res = dv; e.nstb = 1; e.lat = 2; end
                POP, DROP: begin e.res = sm[0]; void'(sm.pop_front()); e.nstb = 1; e.lat = 2; end
                DUP: begin t = sm[0]; sm.push_front(t); e.res = t; e.nstb = 1; e.lat = 2; end
                OVER: begin t = sm[1]; sm.push_front(t); e.res = t; e.nstb = 1; e.lat = 2; end
                SWAP: begin t = sm[0]; sm[0] = sm[1]; sm[1] = t; e.res = sm[0]; e.nstb = 3; e.lat = 4; end
                CLEAR: begin sm.delete(); e.res = 8'h00; end
                default: ;
            endcase
        end
        e.dep = 4'(sm.size());
        last_res = e.res;
        q.push_back(e);
        chk("ready_before_cmd", {31'b0, bus.cmd_ready}, 1);
        base = slog.size();
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_data = dv;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 1;
        while (!bus.done && n < 8) begin
            @(negedge clk);
            n++;
        end
        e = q.pop_front();
        chk($sformatf("done op%0d", op), {31'b0, bus.done}, 1);
        chk($sformatf("latency op%0d", op), n, e.lat);
        chk($sformatf("err op%0d", op), {31'b0, bus.err}, {31'b0, e.err});
        chk($sformatf("result op%0d", op), {24'b0, bus.result}, {24'b0, e.res});
        chk($sformatf("depth op%0d", op), {28'b0, bus.depth}, {28'b0, e.dep});
        chk($sformatf("strobes op%0d", op), slog.size() - base, e.nstb);
        if (sm.size() >= 1) chk("lifo_s0", {24'b0, lm[0]}, {24'b0, sm[0]});
        if (sm.size() >= 2) chk("lifo_s1", {24'b0, lm[1]}, {24'b0, sm[1]});
    endtask
    initial begin
        int acc;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = NOP;
        bus.cmd_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_push", {31'b0, bus.lifo_push}, 0);
        chk("rst_pop", {31'b0, bus.lifo_pop}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_depth", {28'b0, bus.depth}, 0);
        chk("rst_done", {31'b0, bus.done}, 0);
        chk("rst_err", {31'b0, bus.err}, 0);
        chk("rst_result", {24'b0, bus.result}, 0);
        chk("rst_data", {24'b0, bus.lifo_data}, 0);
        chk("rst_empty", {31'b0, bus.empty}, 1);
        chk("rst_full", {31'b0, bus.full}, 0);
        chk("rst_ready", {31'b0, bus.cmd_ready}, 1);
        cmd(POP, 8'h00);
        cmd(DROP, 8'h00);
        cmd(DUP, 8'h00);
        cmd(SWAP, 8'h00);
        cmd(OVER, 8'h00);
        cmd(NOP, 8'h00);
        cmd(PUSH, 8'h11);
        cmd(PUSH, 8'h22);
        cmd(PUSH, 8'h33);
        cmd(SWAP, 8'h00);
        chk("swap_stb0", {30'b0, slog[base][9:8]}, 2'b01);
        chk("swap_stb1", {22'b0, slog[base+1]}, {22'b0, 2'b11, 8'h33});
        chk("swap_stb2", {22'b0, slog[base+2]}, {22'b0, 2'b10, 8'h22});
        cmd(OVER, 8'h00);
        cmd(DUP, 8'h00);
        cmd(PUSH, 8'h44);
        cmd(PUSH, 8'h55);
        cmd(PUSH, 8'h66);
        chk("full_at_8", {31'b0, bus.full}, 1);
        cmd(PUSH, 8'hAA);
        chk("full_after_reject", {31'b0, bus.full}, 1);
        cmd(POP, 8'h00);
        chk("full_after_pop", {31'b0, bus.full}, 0);
        cmd(CLEAR, 8'h00);
        chk("empty_after_clear", {31'b0, bus.empty}, 1);
        cmd(PUSH, 8'h01);
        cmd(SWAP, 8'h00);
        cmd(OVER, 8'h00);
        cmd(DUP, 8'h00);
        cmd(PUSH, 8'h02);
        cmd(PUSH, 8'h03);
        cmd(PUSH, 8'h04);
        // valid held high: single-strobe ops issue every other cycle
        acc = 0;
        base = slog.size();
        bus.cmd_valid = 1'b1;
        bus.cmd_op = POP;
        repeat (8) begin
            if (bus.cmd_ready) acc++;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        repeat (4) last_res = sm.pop_front();
        chk("b2b_accepts", acc, 4);
        chk("b2b_strobes", slog.size() - base, 4);
        chk("b2b_done", {31'b0, bus.done}, 1);
        chk("b2b_result", {24'b0, bus.result}, {24'b0, last_res});
        chk("b2b_depth", {28'b0, bus.depth}, {28'b0, 4'(sm.size())});
        chk("b2b_s0", {24'b0, lm[0]}, {24'b0, sm[0]});
        @(negedge clk);
        cmd(PUSH, 8'h07);
        // reset lands while SWAP is replacing the top
        bus.cmd_valid = 1'b1;
        bus.cmd_op = SWAP;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("swrep_push", {31'b0, bus.lifo_push}, 1);
        chk("swrep_pop", {31'b0, bus.lifo_pop}, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_push", {31'b0, bus.lifo_push}, 0);
        chk("arst_pop", {31'b0, bus.lifo_pop}, 0);
        chk("arst_depth", {28'b0, bus.depth}, 0);
        chk("arst_ready", {31'b0, bus.cmd_ready}, 1);
        sm.delete();
        last_res = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", {31'b0, bus.cmd_ready}, 1);
        chk("post_rst_empty", {31'b0, bus.empty}, 1);
        chk("post_rst_done", {31'b0, bus.done}, 0);
        cmd(PUSH, 8'h5A);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
